// File: rtl/cross_bar_pkt_len_prepend.sv
// cross_bar_pkt_len_prepend
//   Per-input store-and-forward packet buffer placed in front of a
//   deficit-round-robin arbiter input. Whole AXI-Stream packets are stored,
//   then each is emitted as one header beat carrying the packet length in
//   beats (zero-extended) followed by the data beats. A packet is offered only
//   once completely stored. Packets longer than the data FIFO depth are split
//   into maximum-length pieces and oversize_err pulses for each split.
// Ports
//   aclk, aresetn            clock and synchronous active-low reset
//   s_axis_tdata/tvalid/tlast/tready   input packet stream
//   m_axis_tdata/tvalid/tlast/tready   output stream: header, then data beats
//   pkt_count                number of complete packets currently stored
//   oversize_err             one-cycle pulse when a packet is force-split
module cross_bar_pkt_len_prepend #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 6,
  parameter int PKT_NO_LOG2 = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [PKT_NO_LOG2:0]  pkt_count,
  output logic                  oversize_err
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int PKT_NO = 1 << PKT_NO_LOG2;
  localparam int PAD_W  = DATA_WIDTH - DEPTH_LOG2 - 1;

  localparam logic [DEPTH_LOG2:0]    CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]    CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE   = CNT_ONE[DEPTH_LOG2-1:0];
  localparam logic [PKT_NO_LOG2:0]   LCNT_FULL = {1'b1, {PKT_NO_LOG2{1'b0}}};
  localparam logic [PKT_NO_LOG2:0]   LCNT_ONE  = {{PKT_NO_LOG2{1'b0}}, 1'b1};
  localparam logic [PKT_NO_LOG2-1:0] LPTR_ONE  = LCNT_ONE[PKT_NO_LOG2-1:0];

  typedef enum logic [0:0] {ST_HDR = 1'b0, ST_BODY = 1'b1} state_t;

  logic [DATA_WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH_LOG2:0]    len_mem_r [PKT_NO];
  logic [DEPTH_LOG2-1:0]  wr_ptr_r, rd_ptr_r;
  logic [DEPTH_LOG2:0]    data_cnt_r, wr_len_r, rd_left_r;
  logic [PKT_NO_LOG2-1:0] len_wr_ptr_r, len_rd_ptr_r;
  logic [PKT_NO_LOG2:0]   len_cnt_r;
  logic                   oversize_r;
  state_t                 state_r, state_nxt_s;

  logic                   s_ready_s, m_valid_s, m_last_s;
  logic [DATA_WIDTH-1:0]  m_data_s;
  logic                   wr_fire_s, force_s, push_s;
  logic                   rd_fire_s, hdr_fire_s, body_fire_s, pop_s;
  logic [DEPTH_LOG2:0]    wr_len_inc_s, len_head_s;

  assign s_ready_s    = aresetn && (data_cnt_r < CNT_FULL) && (len_cnt_r < LCNT_FULL);
  assign wr_fire_s    = s_axis_tvalid && s_ready_s;
  assign wr_len_inc_s = wr_len_r + CNT_ONE;
  // A packet reaching the FIFO depth is closed even without tlast
  assign force_s      = (wr_len_inc_s == CNT_FULL);
  assign push_s       = wr_fire_s && (s_axis_tlast || force_s);
  assign len_head_s   = len_mem_r[len_rd_ptr_r];
  assign rd_fire_s    = m_valid_s && m_axis_tready;
  assign hdr_fire_s   = rd_fire_s && (state_r == ST_HDR);
  assign body_fire_s  = rd_fire_s && (state_r == ST_BODY);
  assign pop_s        = body_fire_s && (rd_left_r == CNT_ONE);

  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = m_valid_s;
  assign m_axis_tdata  = m_data_s;
  assign m_axis_tlast  = m_last_s;
  assign pkt_count     = len_cnt_r;
  assign oversize_err  = oversize_r && aresetn;

  // Data FIFO storage write port
  always_ff @(posedge aclk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r] <= s_axis_tdata;
    end
  end

  // Length FIFO storage write port
  always_ff @(posedge aclk) begin
    if (push_s) begin
      len_mem_r[len_wr_ptr_r] <= wr_len_inc_s;
    end
  end

  // Write-side pointers, current packet length and split pulse
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_r     <= '0;
      wr_len_r     <= '0;
      len_wr_ptr_r <= '0;
      oversize_r   <= 1'b0;
    end else begin
      oversize_r <= wr_fire_s && force_s && !s_axis_tlast;
      if (wr_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        wr_len_r <= push_s ? '0 : wr_len_inc_s;
      end
      if (push_s) begin
        len_wr_ptr_r <= len_wr_ptr_r + LPTR_ONE;
      end
    end
  end

  // Occupancy counters; simultaneous write/read or push/pop cancel out
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_cnt_r <= '0;
      len_cnt_r  <= '0;
    end else begin
      case ({wr_fire_s, body_fire_s})
        2'b10:   data_cnt_r <= data_cnt_r + CNT_ONE;
        2'b01:   data_cnt_r <= data_cnt_r - CNT_ONE;
        default: data_cnt_r <= data_cnt_r;
      endcase
      case ({push_s, pop_s})
        2'b10:   len_cnt_r <= len_cnt_r + LCNT_ONE;
        2'b01:   len_cnt_r <= len_cnt_r - LCNT_ONE;
        default: len_cnt_r <= len_cnt_r;
      endcase
    end
  end

  // Read-side pointers and remaining-beat counter
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_ptr_r     <= '0;
      rd_left_r    <= '0;
      len_rd_ptr_r <= '0;
    end else begin
      if (hdr_fire_s) begin
        rd_left_r <= len_head_s;
      end else if (body_fire_s) begin
        rd_left_r <= rd_left_r - CNT_ONE;
      end
      if (body_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        len_rd_ptr_r <= len_rd_ptr_r + LPTR_ONE;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HDR: begin
        if (hdr_fire_s) begin
          state_nxt_s = ST_BODY;
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_BODY: begin
        if (pop_s) begin
          state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_BODY;
        end
      end
      default: state_nxt_s = ST_HDR;
    endcase
  end

  // Read FSM outputs; all qualifiers are forced low while reset is held
  always_comb begin
    m_valid_s = 1'b0;
    m_last_s  = 1'b0;
    m_data_s  = '0;
    case (state_r)
      ST_HDR: begin
        m_valid_s = aresetn && (len_cnt_r != '0);
        m_data_s  = {{PAD_W{1'b0}}, len_head_s};
      end
      ST_BODY: begin
        m_valid_s = aresetn;
        m_last_s  = aresetn && (rd_left_r == CNT_ONE);
        m_data_s  = mem_r[rd_ptr_r];
      end
      default: begin
        m_valid_s = 1'b0;
        m_last_s  = 1'b0;
        m_data_s  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cross_bar_pkt_len_prepend.sv
// Bench for cross_bar_pkt_len_prepend: random stimulus checked against a
// packet-level reference model (split at tlast or 64 beats, prepend length).
module tb_cross_bar_pkt_len_prepend;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [2:0]  pkt_count;
  logic        oversize_err;

  cross_bar_pkt_len_prepend #(.DATA_WIDTH(32), .DEPTH_LOG2(6), .PKT_NO_LOG2(2)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count), .oversize_err(oversize_err)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  logic [31:0] in_d[$];
  bit          in_l[$];
  logic [31:0] cur_pkt[$];
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  int gap_pct, rdy_pct, cyc, acc_cnt;
  int oversize_seen, exp_oversize, peak_cnt, stall_viol;
  int first_valid_cyc, first_out_cyc, last_out_cyc, first_lastbeat_cyc, last_accept_cyc;
  bit prev_stall;
  logic [32:0] prev_out;

  // Reference model: store beats, close packet on tlast or at 64 beats.
  function automatic void model_accept(logic [31:0] d, bit l);
    cur_pkt.push_back(d);
    if (l || cur_pkt.size() == 64) begin
      exp_q.push_back({1'b0, 32'(cur_pkt.size())});
      foreach (cur_pkt[i]) exp_q.push_back({1'(i == cur_pkt.size() - 1), cur_pkt[i]});
      if (!l) exp_oversize++;
      cur_pkt.delete();
    end
  endfunction

  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  function automatic void clear_state();
    in_d.delete(); in_l.delete(); cur_pkt.delete(); exp_q.delete(); got_q.delete();
    acc_cnt = 0; oversize_seen = 0; exp_oversize = 0; peak_cnt = 0; stall_viol = 0;
    first_valid_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    first_lastbeat_cyc = -1; last_accept_cyc = -1; prev_stall = 0;
    gap_pct = 0; rdy_pct = 100;
  endfunction

  function automatic void add_pkt(int len, bit with_last);
    for (int i = 0; i < len; i++) begin
      in_d.push_back($urandom);
      in_l.push_back(with_last && (i == len - 1));
    end
  endfunction

  // One clock: drive after the edge, observe at the falling edge.
  task automatic run_cycle();
    @(posedge aclk); #1;
    cyc++;
    if (in_d.size() > 0 && $urandom_range(99, 0) >= gap_pct) begin
      s_axis_tvalid = 1'b1; s_axis_tdata = in_d[0]; s_axis_tlast = in_l[0];
    end else begin
      s_axis_tvalid = 1'b0; s_axis_tdata = $urandom; s_axis_tlast = 1'b0;
    end
    m_axis_tready = ($urandom_range(99, 0) < rdy_pct);
    @(negedge aclk);
    if (prev_stall && !(m_axis_tvalid && {m_axis_tlast, m_axis_tdata} === prev_out)) stall_viol++;
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_out = {m_axis_tlast, m_axis_tdata};
    if (oversize_err) oversize_seen++;
    if (int'(pkt_count) > peak_cnt) peak_cnt = int'(pkt_count);
    if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (s_axis_tvalid && s_axis_tready) begin
      model_accept(in_d[0], in_l[0]);
      void'(in_d.pop_front()); void'(in_l.pop_front());
      acc_cnt++; last_accept_cyc = cyc;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      got_q.push_back({m_axis_tlast, m_axis_tdata});
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      if (m_axis_tlast && first_lastbeat_cyc < 0) first_lastbeat_cyc = cyc;
    end
  endtask

  task automatic run_drain(int max_cycles);
    int n = 0;
    while ((in_d.size() > 0 || got_q.size() < exp_q.size()) && n < max_cycles) begin
      run_cycle(); n++;
    end
    repeat (4) run_cycle();
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %b expected 0", m_axis_tlast); end
    checks++; if (oversize_err !== 1'b0) begin errors++; $display("FAIL rst_oversize: got %b expected 0", oversize_err); end
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL rst_pkt_count: got %0d expected 0", pkt_count); end
    @(posedge aclk); #1; aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b expected 1", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", m_axis_tvalid); end
  endtask

  task automatic test_single();
    int k;
    clear_state();
    add_pkt(3, 1'b1);
    run_drain(50);
    checks++; if (first_valid_cyc !== last_accept_cyc + 1) begin errors++; $display("FAIL single_hdr_time: got cycle %0d expected %0d", first_valid_cyc, last_accept_cyc + 1); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_state();
    add_pkt(1, 1'b1); add_pkt(4, 1'b1);
    rdy_pct = 0;
    for (int n = 0; n < 20 && in_d.size() > 0; n++) run_cycle();
    rdy_pct = 100;
    run_drain(50);
    checks++; if (peak_cnt != 2) begin errors++; $display("FAIL b2b_peak: got %0d expected 2", peak_cnt); end
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL b2b_end_count: got %0d expected 0", pkt_count); end
    checks++; if (last_out_cyc - first_out_cyc != 6) begin errors++; $display("FAIL b2b_gapless: got span %0d expected 6", last_out_cyc - first_out_cyc); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  task automatic test_oversize();
    int k;
    clear_state();
    add_pkt(70, 1'b1);
    run_drain(400);
    checks++; if (oversize_seen != exp_oversize) begin errors++; $display("FAIL ovs_pulses: got %0d expected %0d", oversize_seen, exp_oversize); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovs_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL ovs_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL ovs_end_count: got %0d expected 0", pkt_count); end
  endtask

  task automatic test_full_data();
    int k;
    clear_state();
    add_pkt(64, 1'b1); add_pkt(1, 1'b1);
    rdy_pct = 0;
    repeat (70) run_cycle();
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", s_axis_tready); end
    checks++; if (in_d.size() != 1) begin errors++; $display("FAIL full_pending: got %0d expected 1", in_d.size()); end
    checks++; if (pkt_count !== 3'd1) begin errors++; $display("FAIL full_count: got %0d expected 1", pkt_count); end
    checks++; if (oversize_seen != 0) begin errors++; $display("FAIL full_oversize: got %0d expected 0", oversize_seen); end
    rdy_pct = 100;
    run_drain(400);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL full_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL full_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  task automatic test_len_fifo_full();
    int k;
    clear_state();
    for (int p = 0; p < 5; p++) add_pkt(1, 1'b1);
    rdy_pct = 0;
    repeat (10) run_cycle();
    checks++; if (pkt_count !== 3'd4) begin errors++; $display("FAIL lfull_count: got %0d expected 4", pkt_count); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL lfull_ready: got %b expected 0", s_axis_tready); end
    checks++; if (in_d.size() != 1) begin errors++; $display("FAIL lfull_pending: got %0d expected 1", in_d.size()); end
    rdy_pct = 100;
    run_drain(100);
    checks++; if (last_accept_cyc != first_lastbeat_cyc + 1) begin errors++; $display("FAIL lfull_resume: got cycle %0d expected %0d", last_accept_cyc, first_lastbeat_cyc + 1); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL lfull_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL lfull_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  task automatic test_backpressure();
    int k, lasts;
    clear_state();
    add_pkt(5, 1'b1);
    rdy_pct = 50;
    run_drain(300);
    lasts = 0;
    foreach (got_q[i]) if (got_q[i][32]) lasts++;
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", stall_viol); end
    checks++; if (lasts != 1) begin errors++; $display("FAIL bp_tlast: got %0d expected 1", lasts); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  task automatic test_random();
    int k;
    clear_state();
    for (int p = 0; p < 8; p++) add_pkt($urandom_range(12, 1), 1'b1);
    gap_pct = 30; rdy_pct = 60;
    run_drain(3000);
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd_stable: got %0d changes expected 0", stall_viol); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL rnd_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  task automatic test_mid_reset();
    int k;
    clear_state();
    add_pkt(4, 1'b1);
    for (int n = 0; n < 20 && acc_cnt < 2; n++) run_cycle();
    checks++; if (acc_cnt != 2) begin errors++; $display("FAIL mrst_accept: got %0d expected 2", acc_cnt); end
    @(posedge aclk); #1;
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (pkt_count !== 3'd0) begin errors++; $display("FAIL mrst_count: got %0d expected 0", pkt_count); end
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b expected 0", m_axis_tvalid); end
    clear_state();
    repeat (5) run_cycle();
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mrst_stale: got %0d beats expected 0", got_q.size()); end
    add_pkt(1, 1'b1);
    run_drain(50);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL mrst_beats: got %0d expected %0d", got_q.size(), exp_q.size()); end
    k = first_diff();
    checks++; if (k >= 0) begin errors++; $display("FAIL mrst_data[%0d]: got %h expected %h", k, got_q[k], exp_q[k]); end
  endtask

  initial begin
    cyc = 0;
    clear_state();
    test_reset();
    test_single();
    test_back_to_back();
    test_oversize();
    test_full_data();
    test_len_fifo_full();
    test_backpressure();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
